// File: rtl/wallace_pkg.sv
// wallace_pkg: shared limits, mode encoding and tree-shape helpers for the Wallace multiplier.
// Latency: n/a (compile-time constants and constant functions only).
// Backpressure: n/a.
package wallace_pkg;

    localparam int WIDTH_MIN  = 4;
    localparam int WIDTH_MAX  = 32;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Rows left after 'level' 3:2 levels, starting from 'width' partial products.
    // Each level turns every full group of three rows into two and passes the rest.
    function automatic int rows_at_level(input int width, input int level);
        int n;
        n = width;
        for (int i = 0; i < level; i++) begin
            if (n > 2) n = n - n / 3;
        end
        return n;
    endfunction

    // Number of 3:2 levels needed to bring 'width' rows down to two.
    function automatic int wallace_levels(input int width);
        int n;
        int l;
        n = width;
        l = 0;
        while (n > 2) begin
            n = n - n / 3;
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/csa_row.sv
// csa_row: one 3:2 carry-save compressor across a full-width row.
// Latency: combinational.
// Backpressure: none; pure logic.
// Ports: a, b, c rows in; sum row and left-shifted carry row out (carry out of the MSB is dropped,
//        the product is taken modulo 2^W).
module csa_row
    import wallace_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: pipelined Wallace-tree multiplier, signed (Baugh-Wooley) or unsigned per beat.
// Latency: STAGES cycles from accept to prod/out_valid; sustains one result per cycle.
// Backpressure: one global enable; out_valid && !out_ready freezes every stage and drops in_ready.
// Ports: clk, rst (async, active-high); x, y, signed_mode with in_valid/in_ready on the operand side;
//        prod with out_valid/out_ready on the result side.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 signed_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PW     = 2 * WIDTH;
    localparam int LEVELS = wallace_levels(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_param_check
        $error("wallace_mult_pipe: WIDTH or STAGES out of range");
    end

    logic              en;
    logic              sm;
    logic [STAGES-1:0] v;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = v[STAGES-1];
    assign sm        = (signed_mode == MODE_SIGNED);

    // Valid bits travel with the data; a bubble enters whenever in_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else if (en) begin
            v[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v[k] <= v[k-1];
            end
        end
    end

    // Partial products. Row i holds x*y[i] shifted by i. In signed mode the terms with exactly one
    // sign bit are inverted and the Baugh-Wooley constant 2^WIDTH + 2^(2*WIDTH-1) rides in the
    // otherwise empty upper bits of row 0, so the tree still starts with exactly WIDTH rows.
    logic [WIDTH-1:0][PW-1:0] pp;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        for (genvar b = 0; b < PW; b++) begin : g_bit
            if (b >= i && b < i + WIDTH) begin : g_term
                localparam int J   = b - i;
                localparam bit INV = ((i == WIDTH - 1) != (J == WIDTH - 1));
                assign pp[i][b] = (x[J] & y[i]) ^ (INV ? sm : 1'b0);
            end else if (i == 0 && (b == WIDTH || b == PW - 1)) begin : g_const
                assign pp[i][b] = sm;
            end else begin : g_zero
                assign pp[i][b] = 1'b0;
            end
        end
    end

    // Stage k runs levels [LO, HI) of the tree, then registers. The last stage also runs the
    // carry-propagate add and registers prod directly, so STAGES=1 only registers the adder output.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = (LEVELS * k) / STAGES;
        localparam int HI   = (LEVELS * (k + 1)) / STAGES;
        localparam int NIN  = rows_at_level(WIDTH, LO);
        localparam int NOUT = rows_at_level(WIDTH, HI);

        logic [NIN-1:0][PW-1:0]  cin;
        logic [NOUT-1:0][PW-1:0] cout;

        if (k == 0) begin : g_src_pp
            assign cin = pp;
        end else begin : g_src_reg
            assign cin = g_stage[k-1].g_reg.q;
        end

        for (genvar j = 0; j < HI - LO; j++) begin : g_lvl
            localparam int N  = rows_at_level(WIDTH, LO + j);
            localparam int G  = N / 3;
            localparam int R  = N % 3;
            localparam int NO = 2 * G + R;

            logic [N-1:0][PW-1:0]  cur;
            logic [NO-1:0][PW-1:0] nxt;

            if (j == 0) begin : g_first
                assign cur = cin;
            end else begin : g_chain
                assign cur = g_lvl[j-1].nxt;
            end

            for (genvar g = 0; g < G; g++) begin : g_csa
                csa_row #(.W(PW)) u_csa (
                    .a     (cur[3*g]),
                    .b     (cur[3*g+1]),
                    .c     (cur[3*g+2]),
                    .sum   (nxt[2*g]),
                    .carry (nxt[2*g+1])
                );
            end

            // Rows that did not fill a group of three pass straight to the next level.
            for (genvar r = 0; r < R; r++) begin : g_pass
                assign nxt[2*G+r] = cur[3*G+r];
            end
        end

        if (HI == LO) begin : g_no_levels
            assign cout = cin;
        end else begin : g_levels_out
            assign cout = g_lvl[HI-LO-1].nxt;
        end

        if (k < STAGES - 1) begin : g_reg
            logic [NOUT-1:0][PW-1:0] q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (en) begin
                    q <= cout;
                end
            end
        end else begin : g_cpa
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod <= '0;
                end else if (en) begin
                    prod <= cout[0] + cout[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: directed table, backpressure and reset sequences on a 16x16/3-stage
// instance, plus a randomized width/stage sweep scored against an arithmetic reference.
// Ports: none (top-level bench).
module tb_wallace_mult_pipe;
    import wallace_pkg::*;

    localparam int NV     = 10;
    localparam int NBEATS = 1000;

    int checks = 0;
    int fails = 0;
    int sweep_done_cnt = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sw_rst = 1'b1;
    logic [15:0] x, y;
    logic        signed_mode, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] prod;

    always #5 clk = ~clk;

    wallace_mult_pipe #(.WIDTH(16), .STAGES(3)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .prod        (prod),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        mode;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [0:NV-1];
    vec_t bp  [0:3];

    initial begin
        repeat (3) @(negedge clk);
        sw_rst = 1'b0;
    end

    // Randomized sweep: one instance per WIDTH/STAGES pair, scored by a FIFO of expected products.
    for (genvar gi = 0; gi < 9; gi++) begin : g_sweep
        localparam int W = (gi / 3 == 0) ? 8 : ((gi / 3 == 1) ? 16 : 32);
        localparam int S = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 2 : 4);

        logic [W-1:0]   sx, sy;
        logic           smode, siv, sir, sov, sor;
        logic [2*W-1:0] sprod;
        logic [2*W-1:0] expq [$];
        logic [63:0]    a, b, p;
        int             acc, cycles;

        wallace_mult_pipe #(.WIDTH(W), .STAGES(S)) u_sw (
            .clk         (clk),
            .rst         (sw_rst),
            .x           (sx),
            .y           (sy),
            .signed_mode (smode),
            .in_valid    (siv),
            .in_ready    (sir),
            .prod        (sprod),
            .out_valid   (sov),
            .out_ready   (sor)
        );

        initial begin
            sx = '0; sy = '0; smode = 1'b0; siv = 1'b0; sor = 1'b0;
            acc = 0; cycles = 0;
            repeat (5) @(negedge clk);
            while ((acc < NBEATS || expq.size() != 0) && cycles < 20000) begin
                @(negedge clk);
                cycles++;
                siv = (acc < NBEATS) && ($urandom_range(3) != 0);
                case ($urandom_range(5))
                    0: sx = '1;
                    1: sx = {1'b1, {(W-1){1'b0}}};
                    2: sx = '0;
                    default: sx = W'($urandom);
                endcase
                case ($urandom_range(5))
                    0: sy = '1;
                    1: sy = {1'b1, {(W-1){1'b0}}};
                    2: sy = '0;
                    default: sy = W'($urandom);
                endcase
                smode = 1'($urandom_range(1));
                sor = ($urandom_range(3) != 0);
                #1;
                if (sor && expq.size() == 0) begin
                    check($sformatf("w%0d_s%0d_spurious", W, S), 64'(sov), 64'd0);
                end else if (sor && sov) begin
                    check($sformatf("w%0d_s%0d_prod", W, S), 64'(sprod), 64'(expq.pop_front()));
                end
                if (siv && sir) begin
                    if (smode == MODE_SIGNED) begin
                        a = {{(64-W){sx[W-1]}}, sx};
                        b = {{(64-W){sy[W-1]}}, sy};
                    end else begin
                        a = {{(64-W){1'b0}}, sx};
                        b = {{(64-W){1'b0}}, sy};
                    end
                    p = a * b;
                    expq.push_back(p[2*W-1:0]);
                    acc++;
                end
            end
            check($sformatf("w%0d_s%0d_accepted", W, S), 64'(acc), 64'(NBEATS));
            check($sformatf("w%0d_s%0d_drained", W, S), 64'(expq.size()), 64'd0);
            siv = 1'b0;
            sor = 1'b1;
            repeat (4) begin
                @(negedge clk);
                #1;
                check($sformatf("w%0d_s%0d_idle", W, S), 64'(sov), 64'd0);
            end
            sweep_done_cnt++;
        end
    end

    initial begin
        tbl[0] = '{16'hFFFC, 16'd12,   MODE_SIGNED,   32'hFFFFFFD0, "s_m4_x_12"};
        tbl[1] = '{16'hFFCD, 16'd2,    MODE_SIGNED,   32'hFFFFFF9A, "s_m51_x_2"};
        tbl[2] = '{16'd4011, 16'd142,  MODE_SIGNED,   32'h0008B0DA, "s_4011_x_142"};
        tbl[3] = '{16'hFFFF, 16'd1,    MODE_SIGNED,   32'hFFFFFFFF, "mode_s_ffff_x_1"};
        tbl[4] = '{16'hFFFF, 16'd1,    MODE_UNSIGNED, 32'h0000FFFF, "mode_u_ffff_x_1"};
        tbl[5] = '{16'h8000, 16'h8000, MODE_SIGNED,   32'h40000000, "s_min_x_min"};
        tbl[6] = '{16'hFFFF, 16'hFFFF, MODE_UNSIGNED, 32'hFFFE0001, "u_max_x_max"};
        tbl[7] = '{16'h0000, 16'd142,  MODE_SIGNED,   32'h00000000, "s_0_x_142"};
        tbl[8] = '{16'h0000, 16'd142,  MODE_UNSIGNED, 32'h00000000, "u_0_x_142"};
        tbl[9] = '{16'h8000, 16'h7FFF, MODE_SIGNED,   32'hC0008000, "s_min_x_max"};
        bp[0]  = '{16'd3,    16'd5,    MODE_UNSIGNED, 32'd15,       "bp_a"};
        bp[1]  = '{16'hFFFE, 16'd3,    MODE_SIGNED,   32'hFFFFFFFA, "bp_b"};
        bp[2]  = '{16'd100,  16'd100,  MODE_UNSIGNED, 32'd10000,    "bp_c"};
        bp[3]  = '{16'd7,    16'd7,    MODE_UNSIGNED, 32'd49,       "bp_d"};

        x = '0; y = '0; signed_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_prod", 64'(prod), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back table beats: beat i must show up exactly three cycles after its accept.
        for (int i = 0; i < NV + 4; i++) begin
            @(negedge clk);
            if (i < NV) begin
                x = tbl[i].x; y = tbl[i].y; signed_mode = tbl[i].mode; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            #1;
            if (i < NV) check("tbl_in_ready", 64'(in_ready), 64'd1);
            if (i >= 3 && i < NV + 3) begin
                check({"vld_", tbl[i-3].name}, 64'(out_valid), 64'd1);
                check(tbl[i-3].name, 64'(prod), 64'(tbl[i-3].exp));
            end else begin
                check("tbl_empty", 64'(out_valid), 64'd0);
            end
        end

        // Fill the pipe, stall the output for five cycles while a fourth beat is offered, then drain.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            x = bp[(i < 3) ? i : 3].x;
            y = bp[(i < 3) ? i : 3].y;
            signed_mode = bp[(i < 3) ? i : 3].mode;
            in_valid = (i < 8);
            out_ready = !(i >= 3 && i < 8);
            #1;
            if (i >= 3 && i < 8) begin
                check("bp_stall_vld", 64'(out_valid), 64'd1);
                check("bp_stall_prod", 64'(prod), 64'(bp[0].exp));
                check("bp_stall_in_ready", 64'(in_ready), 64'd0);
            end else if (i >= 8 && i < 11) begin
                check({"vld_", bp[i-8].name}, 64'(out_valid), 64'd1);
                check(bp[i-8].name, 64'(prod), 64'(bp[i-8].exp));
            end else if (i >= 11) begin
                check("bp_after_drain", 64'(out_valid), 64'd0);
            end
        end

        // Two beats in flight, then an asynchronous reset in the middle of a low clock phase.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = 16'd9; y = 16'd11 + 16'(i); signed_mode = MODE_UNSIGNED;
            in_valid = (i < 2);
            out_ready = 1'b1;
        end
        #1;
        check("rstmid_before_vld", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        check("rstmid_prod", 64'(prod), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            check("rstmid_no_stale", 64'(out_valid), 64'd0);
        end

        for (int t = 0; t < 60000 && sweep_done_cnt < 9; t++) @(negedge clk);
        check("sweeps_done", 64'(sweep_done_cnt), 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
